// File: rtl/stage_latency_stats.sv
// stage_latency_stats: per-stage latency statistics collector.
// Captures one elapsed-cycle sample per completed stage transaction and keeps
// count, min, max, saturating sum, dropped-while-frozen count and (optionally)
// a bucketed latency histogram with a one-bin-per-request read port.
// Optional feature macro: STAGE_STATS_HIST_EN (histogram bins, bin index
// logic and read port). When undefined, rd_valid still answers rd_req one
// cycle later with rd_data = 0.
module stage_latency_stats #(
  parameter int WIDTH     = 32,
  parameter int SUM_WIDTH = 48,
  parameter int CNT_WIDTH = 32,
  parameter int NUM_BINS  = 16,
  parameter int BIN_SHIFT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_valid,
  input  logic [WIDTH-1:0]            sample_cycles,
  input  logic                        clear,
  input  logic                        freeze,
  input  logic                        rd_req,
  input  logic [$clog2(NUM_BINS)-1:0] rd_bin,
  output logic                        rd_valid,
  output logic [CNT_WIDTH-1:0]        rd_data,
  output logic [CNT_WIDTH-1:0]        stat_count,
  output logic [WIDTH-1:0]            stat_min,
  output logic [WIDTH-1:0]            stat_max,
  output logic [SUM_WIDTH-1:0]        stat_sum,
  output logic [CNT_WIDTH-1:0]        stat_dropped,
  output logic                        sum_sat,
  output logic                        busy
);

  localparam int IDX_W = $clog2(NUM_BINS);

  // Saturating +1 for counters and histogram bins.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Saturating accumulate; MSB of the result flags an overflow.
  function automatic logic [SUM_WIDTH:0] sat_add(input logic [SUM_WIDTH-1:0] acc,
                                                 input logic [WIDTH-1:0]     s);
    logic [SUM_WIDTH:0] t;
    t = {1'b0, acc} + (SUM_WIDTH+1)'(s);
    if (t[SUM_WIDTH]) begin
      return {1'b1, {SUM_WIDTH{1'b1}}};
    end
    return t;
  endfunction

  // S1 pipeline registers: accepted / dropped markers and the sample value.
  logic             acc_p1;
  logic             drp_p1;
  logic [WIDTH-1:0] smp_p1;
  logic [SUM_WIDTH:0] sum_nxt;

  // S1 control: freeze is sampled only here; clear discards the entering sample.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_p1 <= 1'b0;
      drp_p1 <= 1'b0;
    end else begin
      acc_p1 <= sample_valid & ~freeze;
      drp_p1 <= sample_valid & freeze;
    end
  end

  // S1 data: capture the sample value (qualified by acc_p1).
  always_ff @(posedge clk) begin
    smp_p1 <= sample_cycles;
  end

  assign busy = acc_p1 | drp_p1;

  // S2 sum candidate with overflow flag.
  always_comb begin
    sum_nxt = sat_add(stat_sum, smp_p1);
  end

  // S2: update scalar statistics; clear wins over any update.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      stat_count   <= '0;
      stat_min     <= '1;
      stat_max     <= '0;
      stat_sum     <= '0;
      stat_dropped <= '0;
      sum_sat      <= 1'b0;
    end else begin
      if (acc_p1) begin
        stat_count <= sat_inc(stat_count);
        if (smp_p1 < stat_min) stat_min <= smp_p1;
        if (smp_p1 > stat_max) stat_max <= smp_p1;
        stat_sum <= sum_nxt[SUM_WIDTH-1:0];
        if (sum_nxt[SUM_WIDTH]) sum_sat <= 1'b1;
      end
      if (drp_p1) begin
        stat_dropped <= sat_inc(stat_dropped);
      end
    end
  end

`ifdef STAGE_STATS_HIST_EN
  localparam logic [WIDTH-1:0] IDX_MAX = WIDTH'(NUM_BINS - 1);
  localparam logic [IDX_W:0]   BIN_LIM = (IDX_W+1)'(NUM_BINS);

  logic [WIDTH-1:0]     shifted;
  logic [IDX_W-1:0]     idx_p1;
  logic [CNT_WIDTH-1:0] bins [NUM_BINS];
  logic                 rd_in_range;

  // S1 bin index: shift down, clamp into the last bin.
  always_comb begin
    shifted = sample_cycles >> BIN_SHIFT;
  end

  assign rd_in_range = ({1'b0, rd_bin} < BIN_LIM);

  // S1 data: register the clamped bin index.
  always_ff @(posedge clk) begin
    idx_p1 <= (shifted > IDX_MAX) ? IDX_W'(NUM_BINS - 1) : shifted[IDX_W-1:0];
  end

  // S2: histogram bin increment; flop array so same-bin back-to-back is safe.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < NUM_BINS; i++) bins[i] <= '0;
    end else if (acc_p1) begin
      bins[idx_p1] <= sat_inc(bins[idx_p1]);
    end
  end

  // Read port: registered, returns the bin value before this cycle's update.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= (clear || !rd_in_range) ? '0 : bins[rd_bin];
      end
    end
  end
`else
  logic unused_hist;
  assign unused_hist = ^{rd_bin, BIN_SHIFT[0]};

  // Read port without storage: acknowledge every request with zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_data  <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_stage_latency_stats.sv
// Scoreboard bench for stage_latency_stats: directed stimulus pushes
// hand-computed expectations; a negedge monitor pops and compares them.
module tb_stage_latency_stats;

  localparam int W  = 8;
  localparam int SW = 8;
  localparam int CW = 16;
  localparam int NB = 16;
  localparam int BS = 2;
  localparam int IW = 4;
`ifdef STAGE_STATS_HIST_EN
  localparam bit HIST = 1'b1;
`else
  localparam bit HIST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_valid;
  logic [W-1:0]  sample_cycles;
  logic          clear;
  logic          freeze;
  logic          rd_req;
  logic [IW-1:0] rd_bin;
  logic          rd_valid;
  logic [CW-1:0] rd_data;
  logic [CW-1:0] stat_count;
  logic [W-1:0]  stat_min;
  logic [W-1:0]  stat_max;
  logic [SW-1:0] stat_sum;
  logic [CW-1:0] stat_dropped;
  logic          sum_sat;
  logic          busy;

  stage_latency_stats #(
    .WIDTH(W), .SUM_WIDTH(SW), .CNT_WIDTH(CW), .NUM_BINS(NB), .BIN_SHIFT(BS)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_cycles(sample_cycles),
    .clear(clear), .freeze(freeze), .rd_req(rd_req), .rd_bin(rd_bin),
    .rd_valid(rd_valid), .rd_data(rd_data), .stat_count(stat_count),
    .stat_min(stat_min), .stat_max(stat_max), .stat_sum(stat_sum),
    .stat_dropped(stat_dropped), .sum_sat(sum_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int at;
    int cnt, mn, mx, sum, sat, drp, bsy;
  } stat_t;

  typedef struct {
    int id;
    int at;
    int data;
  } rd_t;

  stat_t sq[$];
  rd_t   rq[$];
  int    checks = 0;
  int    errors = 0;
  int    sid = 0;
  int    rid = 0;

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s#%0d: got %0d expected %0d (cycle %0d)", nm, id, act, exp, cyc);
    end
  endtask

  function automatic int hb(input int v);
    return HIST ? v : 0;
  endfunction

  task automatic push_stat(input int off, input int cnt, input int mn, input int mx,
                           input int sum, input int sat, input int drp, input int bsy);
    stat_t e;
    e.id = sid; e.at = cyc + off;
    e.cnt = cnt; e.mn = mn; e.mx = mx; e.sum = sum; e.sat = sat; e.drp = drp; e.bsy = bsy;
    sid++;
    sq.push_back(e);
  endtask

  task automatic push_reset(input int off);
    push_stat(off, 0, 255, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    clear        = 1'b0;
    rd_req       = 1'b0;
  endtask

  task automatic smp(input int v);
    sample_valid  = 1'b1;
    sample_cycles = W'(v);
  endtask

  task automatic rd(input int b, input int exp);
    rd_t e;
    rd_req = 1'b1;
    rd_bin = IW'(b);
    e.id = rid; e.at = cyc + 1; e.data = exp;
    rid++;
    rq.push_back(e);
  endtask

  // Monitor: compare scalar snapshots at their due cycle, and every rd_valid.
  initial begin
    forever begin
      @(negedge clk);
      while (sq.size() > 0 && sq[0].at <= cyc) begin
        stat_t e;
        e = sq.pop_front();
        if (e.at < cyc) begin
          chk("stat_late", e.id, 64'(cyc), 64'(e.at));
        end else begin
          chk("count",   e.id, 64'(stat_count),   64'(e.cnt));
          chk("min",     e.id, 64'(stat_min),     64'(e.mn));
          chk("max",     e.id, 64'(stat_max),     64'(e.mx));
          chk("sum",     e.id, 64'(stat_sum),     64'(e.sum));
          chk("sum_sat", e.id, 64'(sum_sat),      64'(e.sat));
          chk("dropped", e.id, 64'(stat_dropped), 64'(e.drp));
          chk("busy",    e.id, 64'(busy),         64'(e.bsy));
        end
      end
      if (rd_valid === 1'b1) begin
        if (rq.size() == 0) begin
          chk("rd_unexpected", -1, 64'(rd_valid), 64'(0));
        end else begin
          rd_t r;
          r = rq.pop_front();
          chk("rd_cycle", r.id, 64'(cyc), 64'(r.at));
          chk("rd_data",  r.id, 64'(rd_data), 64'(r.data));
        end
      end else if (rq.size() > 0 && rq[0].at <= cyc) begin
        rd_t r;
        r = rq.pop_front();
        chk("rd_valid_missing", r.id, 64'(rd_valid), 64'(1));
      end
    end
  end

  // Directed stimulus.
  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample_cycles = '0; clear = 1'b0;
    freeze = 1'b0; rd_req = 1'b0; rd_bin = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    push_reset(0);
    tick();

    // Samples 5, 12, 3, 70 back-to-back.
    smp(5);  tick();
    smp(12); push_stat(1, 1, 5, 5, 5, 0, 0, 1); tick();
    smp(3);  tick();
    smp(70); push_stat(2, 4, 3, 70, 90, 0, 0, 0); tick();
    tick();
    rd(0, hb(1));  tick();
    rd(1, hb(1));  tick();
    rd(3, hb(1));  tick();
    rd(15, hb(1)); tick();
    rd(2, 0);      tick();

    // Zero-valued samples.
    clear = 1'b1; push_reset(1); tick();
    smp(0); tick();
    smp(0); tick();
    smp(0); push_stat(2, 3, 0, 0, 0, 0, 0, 0); tick();
    tick();
    rd(0, hb(3)); tick();

    // Freeze drops; a sample in flight survives freeze rising afterwards.
    clear = 1'b1; push_reset(1); tick();
    freeze = 1'b1; smp(8); tick();
    smp(9); tick();
    freeze = 1'b0; smp(4); push_stat(2, 1, 4, 4, 4, 0, 2, 0); tick();
    freeze = 1'b1; tick();
    freeze = 1'b0; tick();

    // Sum saturation, then clear.
    clear = 1'b1; push_reset(1); tick();
    smp(200); tick();
    smp(100); push_stat(2, 2, 100, 200, 255, 1, 0, 0); tick();
    tick();
    rd(15, hb(2)); tick();
    clear = 1'b1; push_reset(1); tick();
    rd(15, 0); tick();

    // Sample followed by clear; sample in the clear cycle.
    smp(6); tick();
    clear = 1'b1; push_reset(1); tick();
    rd(1, 0); tick();
    smp(9); clear = 1'b1; push_reset(2); tick();
    tick();
    tick();

    // Read of a bin in the same cycle S2 updates it.
    smp(4); tick();
    smp(5); tick();
    smp(6); tick();
    smp(7); tick();
    smp(4); tick();
    rd(1, hb(4)); tick();
    rd(1, hb(5)); push_stat(0, 5, 4, 7, 26, 0, 0, 0); tick();
    clear = 1'b1; rd(1, 0); push_reset(1); tick();

    // Mid-operation reset discards in-flight samples.
    smp(10); tick();
    smp(11); rst = 1'b1; push_reset(1); tick();
    rst = 1'b0; tick();
    rd(2, 0); push_reset(0); tick();
    repeat (4) tick();

    chk("stat_queue_left", 0, 64'(sq.size()), 64'(0));
    chk("rd_queue_left",   0, 64'(rq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
